// File: rtl/hpdcache_flush_all_seq.sv
// Flush-all walker: reads the directory set by set and hands every valid+dirty line to the flush controller.
// Latency 2 cycles per clean set, 2+k per set with k dirty lines; alloc valid/nline/way hold until ready.
module hpdcache_flush_all_seq #(
  parameter  int unsigned SETS      = 64,
  parameter  int unsigned WAYS      = 4,
  parameter  int unsigned TAG_WIDTH = 20,
  localparam int unsigned SET_WIDTH = $clog2(SETS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           dir_rd_o,
  output logic [SET_WIDTH-1:0]           dir_rd_set_o,
  input  logic [WAYS-1:0]                dir_rd_valid_i,
  input  logic [WAYS-1:0]                dir_rd_dirty_i,
  input  logic [WAYS*TAG_WIDTH-1:0]      dir_rd_tag_i,
  output logic                           dir_clr_dirty_o,
  output logic [SET_WIDTH-1:0]           dir_clr_set_o,
  output logic [WAYS-1:0]                dir_clr_way_o,
  output logic                           flush_alloc_o,
  input  logic                           flush_alloc_ready_i,
  output logic [TAG_WIDTH+SET_WIDTH-1:0] flush_alloc_nline_o,
  output logic [WAYS-1:0]                flush_alloc_way_o,
  input  logic                           flush_empty_i
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, ISSUE, DRAIN, DONE} state_t;

  state_t                      state_q;
  logic [SET_WIDTH-1:0]        set_q;
  logic [WAYS-1:0]             mask_q;
  logic [WAYS-1:0]             way_q;
  logic [TAG_WIDTH-1:0]        tag_q;
  logic [WAYS*TAG_WIDTH-1:0]   tags_q;

  logic [WAYS-1:0] cap_mask, cap_way, rem_mask, nxt_way;
  logic            accept, last_set;

  function automatic logic [WAYS-1:0] lowest(input logic [WAYS-1:0] m);
    return m & (~m + WAYS'(1));
  endfunction

  function automatic logic [TAG_WIDTH-1:0] sel_tag(input logic [WAYS*TAG_WIDTH-1:0] tags,
                                                   input logic [WAYS-1:0]           oh);
    logic [TAG_WIDTH-1:0] t;
    t = '0;
    for (int w = 0; w < WAYS; w++)
      if (oh[w]) t |= tags[w*TAG_WIDTH +: TAG_WIDTH];
    return t;
  endfunction

  assign cap_mask = dir_rd_valid_i & dir_rd_dirty_i;
  assign cap_way  = lowest(cap_mask);
  assign accept   = flush_alloc_o & flush_alloc_ready_i;
  assign rem_mask = mask_q & ~way_q;
  assign nxt_way  = lowest(rem_mask);
  assign last_set = (set_q == SET_WIDTH'(SETS - 1));

  // The dirty clear rides on the accepting handshake, so it can never lead or lag the alloc.
  assign dir_rd_set_o        = set_q;
  assign dir_clr_dirty_o     = accept;
  assign dir_clr_set_o       = set_q;
  assign dir_clr_way_o       = accept ? way_q : '0;
  assign flush_alloc_way_o   = way_q;
  assign flush_alloc_nline_o = {tag_q, set_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      set_q         <= '0;
      mask_q        <= '0;
      way_q         <= '0;
      tag_q         <= '0;
      tags_q        <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      dir_rd_o      <= 1'b0;
      flush_alloc_o <= 1'b0;
    end else begin
      dir_rd_o <= 1'b0;
      done_o   <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          state_q  <= READ;
          set_q    <= '0;
          busy_o   <= 1'b1;
          dir_rd_o <= 1'b1;
        end
        READ: state_q <= CAPTURE;
        CAPTURE: begin
          mask_q <= cap_mask;
          tags_q <= dir_rd_tag_i;
          if (cap_mask != '0) begin
            state_q       <= ISSUE;
            flush_alloc_o <= 1'b1;
            way_q         <= cap_way;
            tag_q         <= sel_tag(dir_rd_tag_i, cap_way);
          end else if (last_set) begin
            state_q <= DRAIN;
          end else begin
            state_q  <= READ;
            set_q    <= set_q + SET_WIDTH'(1);
            dir_rd_o <= 1'b1;
          end
        end
        ISSUE: if (accept) begin
          mask_q <= rem_mask;
          if (rem_mask != '0) begin
            way_q <= nxt_way;
            tag_q <= sel_tag(tags_q, nxt_way);
          end else begin
            flush_alloc_o <= 1'b0;
            way_q         <= '0;
            tag_q         <= '0;
            if (last_set) begin
              state_q <= DRAIN;
            end else begin
              state_q  <= READ;
              set_q    <= set_q + SET_WIDTH'(1);
              dir_rd_o <= 1'b1;
            end
          end
        end
        DRAIN: if (flush_empty_i) begin
          state_q <= DONE;
          done_o  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
          set_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hpdcache_flush_all_seq.sv
// Directed bench for hpdcache_flush_all_seq: directory model answers reads, scoreboard checks allocs.
module tb_hpdcache_flush_all_seq;

  localparam int SETS = 4;
  localparam int WAYS = 4;
  localparam int TW   = 20;
  localparam int SW   = 2;
  localparam int NW   = TW + SW;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 start_i = 1'b0;
  logic                 busy_o, done_o, dir_rd_o, dir_clr_dirty_o, flush_alloc_o;
  logic [SW-1:0]        dir_rd_set_o, dir_clr_set_o;
  logic [WAYS-1:0]      dir_rd_valid_i = '0, dir_rd_dirty_i = '0;
  logic [WAYS*TW-1:0]   dir_rd_tag_i = '0;
  logic [WAYS-1:0]      dir_clr_way_o, flush_alloc_way_o;
  logic                 flush_alloc_ready_i = 1'b1;
  logic [NW-1:0]        flush_alloc_nline_o;
  logic                 flush_empty_i = 1'b1;

  hpdcache_flush_all_seq #(.SETS(SETS), .WAYS(WAYS), .TAG_WIDTH(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .dir_rd_o(dir_rd_o), .dir_rd_set_o(dir_rd_set_o), .dir_rd_valid_i(dir_rd_valid_i),
    .dir_rd_dirty_i(dir_rd_dirty_i), .dir_rd_tag_i(dir_rd_tag_i),
    .dir_clr_dirty_o(dir_clr_dirty_o), .dir_clr_set_o(dir_clr_set_o), .dir_clr_way_o(dir_clr_way_o),
    .flush_alloc_o(flush_alloc_o), .flush_alloc_ready_i(flush_alloc_ready_i),
    .flush_alloc_nline_o(flush_alloc_nline_o), .flush_alloc_way_o(flush_alloc_way_o),
    .flush_empty_i(flush_empty_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NW-1:0]   nline;
    logic [WAYS-1:0] way;
    logic [SW-1:0]   set;
  } exp_t;

  exp_t q[$];

  logic [WAYS-1:0] mv[SETS];
  logic [WAYS-1:0] md[SETS];
  logic [TW-1:0]   mt[SETS][WAYS];

  int vectors = 0, miscompares = 0;
  int cyc, done_at, done_cnt, rd_exp, rd_cnt, acc_cnt, clr_cnt;
  int stall_left = 0, empty_delay = 0, lo_left = 0;
  bit in_run = 0, prev_rd = 0, have_prev = 0;
  logic [SW-1:0]   prev_set;
  logic [NW-1:0]   prev_nline;
  logic [WAYS-1:0] prev_way;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_dir();
    for (int s = 0; s < SETS; s++) begin
      mv[s] = '0;
      md[s] = '0;
      for (int w = 0; w < WAYS; w++) mt[s][w] = TW'($urandom);
    end
  endtask

  task automatic set_line(input int s, input int w, input bit v, input bit d, input logic [TW-1:0] t);
    mv[s][w] = v;
    md[s][w] = d;
    mt[s][w] = t;
  endtask

  // Samples the current cycle: directory reads, alloc handshakes, clears, done.
  task automatic observe();
    exp_t e;
    if (dir_rd_o) begin
      check("rd_set", 64'(dir_rd_set_o), 64'(rd_exp));
      rd_exp++;
      rd_cnt++;
    end
    prev_rd  = dir_rd_o;
    prev_set = dir_rd_set_o;
    if (in_run && cyc >= 1 && done_at < 0) check("busy_in_walk", 64'(busy_o), 64'd1);
    if (flush_alloc_o && flush_alloc_ready_i) begin
      if (q.size() == 0) begin
        check("unexpected_alloc", 64'(flush_alloc_nline_o), 64'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("alloc_nline", 64'(flush_alloc_nline_o), 64'(e.nline));
        check("alloc_way", 64'(flush_alloc_way_o), 64'(e.way));
        check("clr_strobe", 64'(dir_clr_dirty_o), 64'd1);
        check("clr_set", 64'(dir_clr_set_o), 64'(e.set));
        check("clr_way", 64'(dir_clr_way_o), 64'(e.way));
      end
      acc_cnt++;
      lo_left   = empty_delay;
      have_prev = 0;
    end else if (flush_alloc_o) begin
      if (have_prev) begin
        check("stall_nline", 64'(flush_alloc_nline_o), 64'(prev_nline));
        check("stall_way", 64'(flush_alloc_way_o), 64'(prev_way));
      end
      prev_nline = flush_alloc_nline_o;
      prev_way   = flush_alloc_way_o;
      have_prev  = 1;
    end else begin
      have_prev = 0;
    end
    if (dir_clr_dirty_o) begin
      clr_cnt++;
      md[dir_clr_set_o] = md[dir_clr_set_o] & ~dir_clr_way_o;
    end
    if (done_o) begin
      done_cnt++;
      if (done_at < 0) done_at = cyc;
    end
  endtask

  // Directory answers one cycle after a read; otherwise junk to catch early sampling.
  task automatic drive();
    if (prev_rd) begin
      dir_rd_valid_i = mv[prev_set];
      dir_rd_dirty_i = md[prev_set];
      for (int w = 0; w < WAYS; w++) dir_rd_tag_i[w*TW +: TW] = mt[prev_set][w];
    end else begin
      dir_rd_valid_i = WAYS'($urandom);
      dir_rd_dirty_i = WAYS'($urandom);
      for (int w = 0; w < WAYS; w++) dir_rd_tag_i[w*TW +: TW] = TW'($urandom);
    end
    if (flush_alloc_o && stall_left > 0) begin
      flush_alloc_ready_i = 1'b0;
      stall_left--;
    end else begin
      flush_alloc_ready_i = 1'b1;
    end
    if (lo_left > 0) begin
      flush_empty_i = 1'b0;
      lo_left--;
    end else begin
      flush_empty_i = 1'b1;
    end
  endtask

  task automatic cycle();
    #1;
    observe();
    @(posedge clk_i);
    #1;
    cyc++;
    drive();
  endtask

  task automatic push_expected();
    exp_t e;
    q.delete();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (mv[s][w] && md[s][w]) begin
          e.nline = {mt[s][w], SW'(s)};
          e.way   = WAYS'(1) << w;
          e.set   = SW'(s);
          q.push_back(e);
        end
  endtask

  task automatic begin_run();
    push_expected();
    cyc = 0; done_at = -1; done_cnt = 0; rd_exp = 0; rd_cnt = 0;
    acc_cnt = 0; clr_cnt = 0; have_prev = 0; in_run = 1;
  endtask

  task automatic run_flush(input string name, input int exp_done, input bit poke);
    logic [WAYS-1:0] res;
    begin_run();
    start_i = 1'b1;
    cycle();
    while (done_at < 0 && cyc < 400) begin
      start_i = (poke && cyc == 4);
      cycle();
    end
    start_i = 1'b0;
    in_run  = 0;
    check({name, "_done_cycle"}, 64'(done_at), 64'(exp_done));
    for (int i = 0; i < 3; i++) begin
      cycle();
      check({name, "_busy_after"}, 64'(busy_o), 64'd0);
    end
    res = '0;
    for (int s = 0; s < SETS; s++) res |= mv[s] & md[s];
    check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({name, "_reads"}, 64'(rd_cnt), 64'(SETS));
    check({name, "_left_in_q"}, 64'(q.size()), 64'd0);
    check({name, "_clears"}, 64'(clr_cnt), 64'(acc_cnt));
    check({name, "_residue"}, 64'(res), 64'd0);
  endtask

  initial begin
    int guard;
    clear_dir();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_rd", 64'(dir_rd_o), 64'd0);
    check("rst_alloc", 64'(flush_alloc_o), 64'd0);
    check("rst_clr", 64'(dir_clr_dirty_o), 64'd0);
    check("rst_nline", 64'(flush_alloc_nline_o), 64'd0);
    check("rst_way", 64'(flush_alloc_way_o), 64'd0);
    check("rst_rd_set", 64'(dir_rd_set_o), 64'd0);

    // All clean; a second start mid-walk must be ignored.
    clear_dir();
    run_flush("clean", 10, 1'b1);

    // Set 2 ways 1,3 dirty; invalid-but-dirty and valid-but-clean lines elsewhere.
    clear_dir();
    set_line(2, 1, 1, 1, 20'h00011);
    set_line(2, 3, 1, 1, 20'h00033);
    set_line(0, 0, 0, 1, 20'h0DEAD);
    set_line(1, 2, 1, 0, 20'h0BEEF);
    run_flush("two_dirty", 12, 1'b0);

    // Ready held low 5 cycles on the first alloc.
    clear_dir();
    set_line(1, 2, 1, 1, 20'hABCDE);
    set_line(3, 0, 1, 1, 20'h00042);
    stall_left = 5;
    run_flush("stall", 17, 1'b0);

    // Whole last set dirty; controller stays non-empty 7 cycles after each alloc.
    clear_dir();
    for (int w = 0; w < WAYS; w++) set_line(3, w, 1, 1, TW'(32'h100 + w));
    empty_delay = 7;
    run_flush("drain", 21, 1'b0);
    empty_delay = 0;

    // Reset while an alloc is pending, then a fresh walk from set 0.
    clear_dir();
    set_line(1, 0, 1, 1, 20'h55555);
    stall_left = 1000;
    begin_run();
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    guard = 0;
    while (!flush_alloc_o && guard < 50) begin
      cycle();
      guard++;
    end
    check("abort_alloc_seen", 64'(flush_alloc_o), 64'd1);
    repeat (2) cycle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    stall_left = 0;
    in_run = 0;
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_no_accept", 64'(acc_cnt), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_alloc", 64'(flush_alloc_o), 64'd0);
    check("abort_rd", 64'(dir_rd_o), 64'd0);
    check("abort_nline", 64'(flush_alloc_nline_o), 64'd0);
    check("abort_way", 64'(flush_alloc_way_o), 64'd0);
    check("abort_rd_set", 64'(dir_rd_set_o), 64'd0);
    repeat (2) cycle();
    flush_alloc_ready_i = 1'b1;
    run_flush("rewalk", 11, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
